dds_wave_env: RTL and testbench

DDS_WAVE_ENV -- requirements
Module: dds_wave_env

---
 rtl/dds_wave_env.sv | 137 +++++++++++++
 tb/tb_dds_wave_env.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dds_wave_env.sv
// DDS waveform shaper (saw/square/triangle/silent) scaled by an ADSR-style envelope; PHASE->SAMPLE latency 2 cycles.
// Streams one sample per cycle with no stalls; reset is synchronous and active-low.
module dds_wave_env (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] phase,
   input  logic [1:0]  wave_sel,
   input  logic [7:0]  pulse_w,
   input  logic        gate,
   input  logic [7:0]  attack_rate,
   input  logic [7:0]  release_rate,
   output logic [11:0] sample,
   output logic [7:0]  env,
   output logic        active,
   output logic        sample_valid
);

   typedef enum logic [1:0] {S_IDLE, S_ATTACK, S_SUSTAIN, S_RELEASE} state_t;

   state_t      state_q, state_d;
   logic [7:0]  env_q, env_d;
   logic [7:0]  pre_q, pre_d;
   logic [11:0] w_q, w_d;
   logic [11:0] sample_q, sample_d;
   logic        active_q, active_d;
   logic        vld1_q, vld1_d;
   logic        sample_valid_q, sample_valid_d;
   logic [19:0] prod;
   logic        unused_phase_bits;

   assign unused_phase_bits = ^phase[18:0];

   always_comb begin
      w_d = '0;
      case (wave_sel)
         2'd0: w_d = phase[31:20];
         2'd1: w_d = (phase[31:24] < pulse_w) ? 12'hFFF : 12'h000;
         2'd2: w_d = phase[31] ? ~phase[30:19] : phase[30:19];
         default: w_d = '0;
      endcase
   end

   // Stage 2 uses the envelope as it stands when the raw wave is already registered.
   always_comb begin
      prod           = {8'd0, w_q} * {12'd0, env_q};
      sample_d       = prod[19:8];
      vld1_d         = 1'b1;
      sample_valid_d = vld1_q;
   end

   always_comb begin
      state_d = state_q;
      env_d   = env_q;
      pre_d   = pre_q;
      case (state_q)
         S_IDLE: begin
            env_d = '0;
            if (gate) begin
               state_d = S_ATTACK;
               pre_d   = '0;
            end
         end
         S_ATTACK: begin
            if (!gate) begin
               state_d = S_RELEASE;
               pre_d   = '0;
            end else if (env_q == 8'd255) begin
               state_d = S_SUSTAIN;
               pre_d   = '0;
            end else if (pre_q == attack_rate) begin
               env_d = env_q + 8'd1;
               pre_d = '0;
               if (env_q == 8'd254) state_d = S_SUSTAIN;
            end else begin
               pre_d = pre_q + 8'd1;
            end
         end
         S_SUSTAIN: begin
            env_d = 8'd255;
            if (!gate) begin
               state_d = S_RELEASE;
               pre_d   = '0;
            end
         end
         S_RELEASE: begin
            // Retrigger resumes from the current level rather than restarting at zero.
            if (gate) begin
               state_d = (env_q == 8'd255) ? S_SUSTAIN : S_ATTACK;
               pre_d   = '0;
            end else if (env_q == 8'd0) begin
               state_d = S_IDLE;
               pre_d   = '0;
            end else if (pre_q == release_rate) begin
               env_d = env_q - 8'd1;
               pre_d = '0;
               if (env_q == 8'd1) state_d = S_IDLE;
            end else begin
               pre_d = pre_q + 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            env_d   = '0;
            pre_d   = '0;
         end
      endcase
      active_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         env_q          <= '0;
         pre_q          <= '0;
         w_q            <= '0;
         sample_q       <= '0;
         active_q       <= 1'b0;
         vld1_q         <= 1'b0;
         sample_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         env_q          <= env_d;
         pre_q          <= pre_d;
         w_q            <= w_d;
         sample_q       <= sample_d;
         active_q       <= active_d;
         vld1_q         <= vld1_d;
         sample_valid_q <= sample_valid_d;
      end
   end

   assign sample       = sample_q;
   assign env          = env_q;
   assign active       = active_q;
   assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_dds_wave_env.sv
// Directed bench for dds_wave_env: waveform vector table at full envelope plus envelope ramps,
// retrigger, gate priority and reset-abort sequences.
module tb_dds_wave_env;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] phase;
   logic [1:0]  wave_sel;
   logic [7:0]  pulse_w;
   logic        gate;
   logic [7:0]  attack_rate;
   logic [7:0]  release_rate;
   logic [11:0] sample;
   logic [7:0]  env;
   logic        active;
   logic        sample_valid;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [1:0]  sel;
      logic [31:0] ph;
      logic [7:0]  pw;
      int          exp;
   } vec_t;

   vec_t vecs [12];

   dds_wave_env dut (
      .clk          (clk),
      .reset        (reset),
      .phase        (phase),
      .wave_sel     (wave_sel),
      .pulse_w      (pulse_w),
      .gate         (gate),
      .attack_rate  (attack_rate),
      .release_rate (release_rate),
      .sample       (sample),
      .env          (env),
      .active       (active),
      .sample_valid (sample_valid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      // Expected samples at ENV=255: (W*255)>>8.
      vecs[0]  = '{2'd1, 32'h7FFF_FFFF, 8'd128, 4079};
      vecs[1]  = '{2'd1, 32'h8000_0000, 8'd128, 0};
      vecs[2]  = '{2'd1, 32'h0000_0000, 8'd0,   0};
      vecs[3]  = '{2'd1, 32'h7FFF_FFFF, 8'd0,   0};
      vecs[4]  = '{2'd2, 32'h4000_0000, 8'd0,   2040};
      vecs[5]  = '{2'd2, 32'hC000_0000, 8'd0,   2039};
      vecs[6]  = '{2'd2, 32'h0000_0000, 8'd0,   0};
      vecs[7]  = '{2'd0, 32'hFFF0_0000, 8'd0,   4079};
      vecs[8]  = '{2'd0, 32'h8000_0000, 8'd0,   2040};
      vecs[9]  = '{2'd0, 32'h0010_0000, 8'd0,   0};
      vecs[10] = '{2'd0, 32'h1234_5678, 8'd0,   289};
      vecs[11] = '{2'd3, 32'hFFFF_FFFF, 8'd255, 0};

      reset = 1'b0; gate = 1'b1; phase = '0; wave_sel = 2'd3; pulse_w = '0;
      attack_rate = 8'd0; release_rate = 8'd0;

      // Reset held with gate high
      repeat (5) tick();
      chk("rst_sample", sample, 0);
      chk("rst_env", env, 0);
      chk("rst_active", active, 0);
      chk("rst_valid", sample_valid, 0);

      reset = 1'b1;
      tick();
      chk("rel1_active", active, 1);
      chk("rel1_valid", sample_valid, 0);
      chk("rel1_env", env, 0);
      tick();
      chk("rel2_valid", sample_valid, 1);
      chk("rel2_env", env, 1);

      // Attack at rate 0: ENV reaches 255 on the 256th edge
      repeat (253) tick();
      chk("atk_254", env, 254);
      tick();
      chk("atk_255", env, 255);
      repeat (10) tick();
      chk("sustain_hold", env, 255);
      chk("sustain_active", active, 1);

      for (int i = 0; i < 12; i++) begin
         wave_sel = vecs[i].sel;
         phase    = vecs[i].ph;
         pulse_w  = vecs[i].pw;
         tick();
         tick();
         chk($sformatf("wave_vec%0d", i), sample, vecs[i].exp);
      end

      // Back-to-back samples, two-cycle latency
      wave_sel = 2'd0; phase = 32'hFFF0_0000;
      tick();
      phase = 32'h8000_0000;
      tick();
      chk("pipe_a", sample, 4079);
      phase = 32'h0000_0000;
      tick();
      chk("pipe_b", sample, 2040);
      tick();
      chk("pipe_c", sample, 0);

      // Release at rate 3 from sustain
      gate = 1'b0; release_rate = 8'd3;
      tick();
      chk("rls_enter", env, 255);
      repeat (3) tick();
      chk("rls_e3", env, 255);
      tick();
      chk("rls_e4", env, 254);
      repeat (1015) tick();
      chk("rls_e1019", env, 1);
      chk("rls_e1019_act", active, 1);
      tick();
      chk("rls_e1020", env, 0);
      chk("rls_idle", active, 0);
      tick();
      chk("idle_stay", active, 0);

      // Retrigger during release at ENV=100
      gate = 1'b1; attack_rate = 8'd0;
      repeat (151) tick();
      chk("rt_up150", env, 150);
      gate = 1'b0; release_rate = 8'd0;
      tick();
      chk("rt_rls_enter", env, 150);
      repeat (50) tick();
      chk("rt_at100", env, 100);
      gate = 1'b1;
      tick();
      chk("rt_hold100", env, 100);
      tick();
      chk("rt_101", env, 101);
      tick();
      chk("rt_102", env, 102);
      repeat (26) tick();
      chk("rt_128", env, 128);

      // Saw scaled by ENV=128, then silent
      attack_rate = 8'd255; wave_sel = 2'd0; phase = 32'hFFF0_0000;
      tick();
      tick();
      chk("saw_env128", sample, 2047);
      chk("env_slow_hold", env, 128);
      wave_sel = 2'd3;
      tick();
      tick();
      chk("silent_env128", sample, 0);

      // Gate drop beats a same-edge attack step
      attack_rate = 8'd0; gate = 1'b0;
      tick();
      chk("gate_prio_env", env, 128);
      chk("gate_prio_act", active, 1);
      tick();
      chk("gate_prio_rls", env, 127);

      // Reset mid-note aborts immediately
      reset = 1'b0;
      tick();
      chk("mid_rst_env", env, 0);
      chk("mid_rst_act", active, 0);
      chk("mid_rst_sample", sample, 0);
      chk("mid_rst_valid", sample_valid, 0);
      reset = 1'b1; gate = 1'b1;
      tick();
      chk("restart_env0", env, 0);
      chk("restart_act", active, 1);
      gate = 1'b0;
      tick();
      chk("zero_rls_env", env, 0);
      chk("zero_rls_act", active, 1);
      tick();
      chk("zero_rls_idle_env", env, 0);
      chk("zero_rls_idle_act", active, 0);
      chk("valid_kept", sample_valid, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
